// File: rtl/clkdiv_seq_pkg.sv
// Shared definitions for the clock-divider burst sequencer: FSM state encoding
// and the default counter widths and watchdog limit.
package clkdiv_seq_pkg;

   localparam int unsigned CNT_W_DEF          = 32;
   localparam int unsigned BURST_W_DEF        = 16;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd1_000_000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/clkdiv_edge_counter.sv
// Rising-edge detector on the divided clock plus a saturating edge counter
// with synchronous clear and a "target reached" flag.
module clkdiv_edge_counter
   import clkdiv_seq_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clk_div_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] target_i,
   output logic             reached_o
);

   logic             prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             rise;

   assign rise = clk_div_i & ~prev_q;

   // Counting stops at the target so the count can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && rise && (cnt_q < target_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prev_q <= clk_div_i;
         cnt_q  <= cnt_d;
      end
   end

   assign reached_o = (cnt_q >= target_i);

endmodule

// File: rtl/clkdiv_burst_sequencer.sv
// Sequences the clock_divider through a programmed series of bursts separated by gaps.
// Optional per-burst watchdog is built when CLKDIV_SEQ_TIMEOUT_EN is defined.
module clkdiv_burst_sequencer
   import clkdiv_seq_pkg::*;
#(
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter int unsigned BURST_W        = BURST_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic               I_CLK,
   input  logic               I_RSTn,
   input  logic               I_ENABLE,
   input  logic               I_ABORT,
   input  logic [CNT_W-1:0]   I_DIV_FACTOR,
   input  logic [CNT_W-1:0]   I_ACTIVE_COUNT,
   input  logic [BURST_W-1:0] I_BURST_COUNT,
   input  logic [CNT_W-1:0]   I_GAP_CYCLES,
   input  logic               I_CLK_DIV,
   output logic               O_DIV_START,
   output logic [CNT_W-1:0]   O_DIV_FACTOR,
   output logic [CNT_W-1:0]   O_DIV_ACTIVE_COUNT,
   output logic               O_BUSY,
   output logic               O_DONE,
   output logic               O_CFG_ERR,
   output logic [BURST_W-1:0] O_BURST_IDX,
   output logic               O_TIMEOUT
);

   function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cfg_factor_q, cfg_factor_d;
   logic [CNT_W-1:0]   cfg_active_q, cfg_active_d;
   logic [BURST_W-1:0] cfg_bursts_q, cfg_bursts_d;
   logic [CNT_W-1:0]   cfg_gap_q, cfg_gap_d;
   logic [CNT_W-1:0]   div_factor_q, div_factor_d;
   logic [CNT_W-1:0]   div_active_q, div_active_d;
   logic               start_q, start_d;
   logic               cfg_err_q, cfg_err_d;
   logic [BURST_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [BURST_W-1:0] last_idx;
   logic               cnt_en;
   logic               cnt_clr;
   logic               cnt_reached;

`ifdef CLKDIV_SEQ_TIMEOUT_EN
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] wd_q, wd_d;
   logic        timeout_q, timeout_d;
`endif

   assign last_idx = cfg_bursts_q - BURST_W'(1);

   clkdiv_edge_counter #(
      .CNT_W(CNT_W)
   ) u_edge_cnt (
      .clk_i    (I_CLK),
      .rst_ni   (I_RSTn),
      .clk_div_i(I_CLK_DIV),
      .en_i     (cnt_en),
      .clr_i    (cnt_clr),
      .target_i (cfg_active_q),
      .reached_o(cnt_reached)
   );

   always_comb begin
      state_d      = state_q;
      cfg_factor_d = cfg_factor_q;
      cfg_active_d = cfg_active_q;
      cfg_bursts_d = cfg_bursts_q;
      cfg_gap_d    = cfg_gap_q;
      div_factor_d = div_factor_q;
      div_active_d = div_active_q;
      start_d      = 1'b0;
      cfg_err_d    = 1'b0;
      idx_d        = idx_q;
      gap_cnt_d    = gap_cnt_q;
      cnt_en       = 1'b0;
      cnt_clr      = 1'b1;
`ifdef CLKDIV_SEQ_TIMEOUT_EN
      wd_d         = '0;
      timeout_d    = timeout_q;
`endif

      // Abort has priority over everything, including a same-cycle enable.
      if (I_ABORT) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (I_ENABLE) begin
                  if (I_DIV_FACTOR == '0) begin
                     cfg_err_d = 1'b1;
                  end else if ((I_BURST_COUNT == '0) || (I_ACTIVE_COUNT == '0)) begin
                     state_d = ST_DONE;
                  end else begin
                     cfg_factor_d = I_DIV_FACTOR;
                     cfg_active_d = I_ACTIVE_COUNT;
                     cfg_bursts_d = I_BURST_COUNT;
                     cfg_gap_d    = at_least_one(I_GAP_CYCLES);
`ifdef CLKDIV_SEQ_TIMEOUT_EN
                     timeout_d    = 1'b0;
`endif
                     state_d      = ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               div_factor_d = cfg_factor_q;
               div_active_d = cfg_active_q;
               idx_d        = '0;
               state_d      = ST_RUN;
            end
            ST_RUN: begin
               cnt_en  = 1'b1;
               cnt_clr = 1'b0;
               if (cnt_reached) begin
                  gap_cnt_d = '0;
                  state_d   = (idx_q == last_idx) ? ST_DONE : ST_GAP;
               end else begin
                  start_d = 1'b1;
               end
            end
            ST_GAP: begin
               // Start is raised on the exit edge so it is low for exactly cfg_gap cycles.
               if (gap_cnt_q == (cfg_gap_q - CNT_W'(1))) begin
                  start_d = 1'b1;
                  state_d = ST_RUN;
                  if (idx_q != last_idx) begin
                     idx_d = idx_q + BURST_W'(1);
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

`ifdef CLKDIV_SEQ_TIMEOUT_EN
         if ((state_q == ST_RUN) && !cnt_reached) begin
            if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               start_d   = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               wd_d = wd_q + 32'd1;
            end
         end
`endif
      end
   end

   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         state_q      <= ST_IDLE;
         cfg_factor_q <= '0;
         cfg_active_q <= '0;
         cfg_bursts_q <= '0;
         cfg_gap_q    <= '0;
         div_factor_q <= '0;
         div_active_q <= '0;
         start_q      <= 1'b0;
         cfg_err_q    <= 1'b0;
         idx_q        <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         cfg_factor_q <= cfg_factor_d;
         cfg_active_q <= cfg_active_d;
         cfg_bursts_q <= cfg_bursts_d;
         cfg_gap_q    <= cfg_gap_d;
         div_factor_q <= div_factor_d;
         div_active_q <= div_active_d;
         start_q      <= start_d;
         cfg_err_q    <= cfg_err_d;
         idx_q        <= idx_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

`ifdef CLKDIV_SEQ_TIMEOUT_EN
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign O_TIMEOUT = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
   assign O_TIMEOUT          = 1'b0;
`endif

   assign O_DIV_START        = start_q;
   assign O_DIV_FACTOR       = div_factor_q;
   assign O_DIV_ACTIVE_COUNT = div_active_q;
   assign O_BUSY             = (state_q != ST_IDLE);
   assign O_DONE             = (state_q == ST_DONE);
   assign O_CFG_ERR          = cfg_err_q;
   assign O_BURST_IDX        = idx_q;

endmodule

// File: doc/clkdiv_burst_sequencer.md
Name: clkdiv_burst_sequencer

Overview:
- Controller that sequences the DAQ clock_divider through a programmed series of bursts.
- Latches a burst configuration, drives the divider's start/factor/active-count inputs, and counts divided-clock rising edges to detect end of each burst.
- Inserts a programmable gap between bursts and reports done, error and timeout to the AXI register wrapper.

Parameters:
- CNT_W, 32, width of div factor, active count and gap counters
- BURST_W, 16, width of burst count/index
- TIMEOUT_CYCLES, 32'd1_000_000, per-burst watchdog limit in I_CLK cycles (used only with macro)

Ports:
- I_CLK  in  1  system clock; divider runs on the same clock
- I_RSTn  in  1  asynchronous active-low reset
- I_ENABLE  in  1  1-cycle go pulse, sampled only in IDLE
- I_ABORT  in  1  level/pulse, forces return to IDLE
- I_DIV_FACTOR  in  CNT_W  divide factor for all bursts
- I_ACTIVE_COUNT  in  CNT_W  divided-clock rising edges per burst
- I_BURST_COUNT  in  BURST_W  number of bursts
- I_GAP_CYCLES  in  CNT_W  I_CLK cycles with start low between bursts
- I_CLK_DIV  in  1  divider output (registered, I_CLK domain)
- O_DIV_START  out  1  to divider I_START
- O_DIV_FACTOR  out  CNT_W  to divider I_DIV_FACTOR
- O_DIV_ACTIVE_COUNT  out  CNT_W  to divider I_ACTIVE_COUNT
- O_BUSY  out  1  high outside IDLE
- O_DONE  out  1  1-cycle pulse on normal completion
- O_CFG_ERR  out  1  1-cycle pulse on rejected config
- O_BURST_IDX  out  BURST_W  index of current/last burst, 0-based
- O_TIMEOUT  out  1  sticky, cleared on next accepted I_ENABLE

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; edge-detect register 0.
- FSM states: IDLE, LOAD, RUN, GAP, DONE.
- IDLE + I_ENABLE:
  - I_DIV_FACTOR == 0: pulse O_CFG_ERR next cycle and stay IDLE.
  - I_BURST_COUNT == 0 or I_ACTIVE_COUNT == 0: go to DONE. O_DIV_START is never asserted.
  - Otherwise: latch all config inputs, clear O_TIMEOUT, go to LOAD.
- LOAD (1 cycle): O_DIV_FACTOR/O_DIV_ACTIVE_COUNT take latched values; O_BUSY=1; O_BURST_IDX=0. Next state RUN.
  - Latency: ENABLE sampled at edge n, outputs valid after n+1, O_DIV_START high after n+2.
- RUN:
  - O_DIV_START=1; rising edge of I_CLK_DIV = I_CLK_DIV & ~prev, where prev is registered every cycle.
  - Edge counter counts up from 0. When the counter reaches the latched active count, O_DIV_START drops on the next edge.
  - If O_BURST_IDX == burst_count-1, go to DONE; else go to GAP.
- GAP:
  - O_DIV_START=0 for max(gap,1) cycles, so start is always low for at least one cycle between bursts.
  - Then O_BURST_IDX increments, the edge counter clears, and state returns to RUN.
- DONE (1 cycle): O_DONE=1, O_DIV_START=0. Next state IDLE; O_BUSY falls with it.
- Config inputs changing while busy are ignored. I_ENABLE while busy is ignored.
- I_ABORT in any state:
  - Next state IDLE, O_DIV_START=0, no O_DONE.
  - O_DIV_FACTOR/O_DIV_ACTIVE_COUNT hold their last values; O_BURST_IDX holds.
  - I_ABORT and I_ENABLE in the same cycle: abort wins.
- Counters never wrap: the edge counter saturates at the latched active count; the burst index is bounded by the burst count.
- Asynchronous reset mid-burst: immediate return to reset values, including O_DIV_START=0.

Optional Feature:
- Macro CLKDIV_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts I_CLK cycles in RUN and clears on RUN entry.
  - Reaching TIMEOUT_CYCLES without completing sets O_TIMEOUT (sticky), drops O_DIV_START, and goes to IDLE with no O_DONE.
- Undefined: no watchdog logic; O_TIMEOUT tied 0.

Decomposition:
- Package clkdiv_seq_pkg: state encoding constants (IDLE=0, LOAD=1, RUN=2, GAP=3, DONE=4), default CNT_W/BURST_W, TIMEOUT_CYCLES default.
- One natural sub-module: clkdiv_edge_counter, holding the rising-edge detect plus saturating edge counter with clear and a reached flag.
- FSM, gap counter and watchdog stay in the top module.

Test Plan:
- Bench with the real clock_divider: factor=2, active=4, bursts=1, gap=0, ENABLE pulse -> O_DIV_START high 2 cycles after ENABLE, exactly 4 I_CLK_DIV rising edges, O_DONE one pulse, O_BUSY low the cycle after.
- factor=4, active=10, bursts=3, gap=5 -> three start-high windows of 10 edges each, start low exactly 5 cycles between them, O_BURST_IDX 0,1,2, single O_DONE.
- bursts=2, gap=0 -> start low exactly 1 cycle between bursts; 2×active edges total.
- factor=0 -> O_CFG_ERR pulse, O_BUSY stays 0, O_DIV_START never high. bursts=0 -> O_DONE within 2 cycles, start never high.
- factor=8, active=10, I_ABORT after 3rd edge -> O_DIV_START low next cycle, IDLE, no O_DONE; simultaneous ENABLE+ABORT in IDLE -> stays IDLE.
- With CLKDIV_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, I_CLK_DIV held 0 -> O_TIMEOUT set at cycle 50 of RUN, start dropped, no O_DONE; next ENABLE clears O_TIMEOUT.
